// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  // Serializer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Register byte offsets from the base address
  localparam int unsigned DATA_OFS   = 0;
  localparam int unsigned STATUS_OFS = 4;

  // Status register bit positions
  localparam int unsigned BUSY  = 0;
  localparam int unsigned FULL  = 1;
  localparam int unsigned EMPTY = 2;
  localparam int unsigned OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  // Flags and head-of-queue view; a push into a full FIFO is taken when a pop frees a slot
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    dout    = mem_q[rd_ptr_q[AW-1:0]];
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
  end

  // Next pointer and storage state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
  end

  // Pointer and storage registers; storage content is don't-care after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: data/status registers, byte queue, serializer.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0080_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic        rd_hit,
  output logic [31:0] rd_data,
  output logic        tx
);

  localparam int unsigned        BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]  BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]        DATA_ADDR   = BASE_ADDR + 32'(DATA_OFS);
  localparam logic [31:0]        STATUS_ADDR = BASE_ADDR + 32'(STATUS_OFS);

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                overflow_q, overflow_d;

  logic                hit_data_c, hit_stat_c;
  logic                wr_data_c, wr_stat_c;
  logic                fifo_pop_c, fifo_full, fifo_empty;
  logic [7:0]          fifo_dout;
  logic                baud_end_c;
  logic [31:0]         status_c;
  logic                unused_wdata_c;

  assign unused_wdata_c = ^write_data[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data_c),
    .pop   (fifo_pop_c),
    .din   (write_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Exact address decode, status assembly and combinational read path
  always_comb begin
    hit_data_c       = (address == DATA_ADDR);
    hit_stat_c       = (address == STATUS_ADDR);
    wr_data_c        = MemWrite && hit_data_c;
    wr_stat_c        = MemWrite && hit_stat_c;
    status_c         = '0;
    status_c[BUSY]   = (state_q != IDLE);
    status_c[FULL]   = fifo_full;
    status_c[EMPTY]  = fifo_empty;
    status_c[OVF]    = overflow_q;
    rd_hit           = MemRead && (hit_data_c || hit_stat_c);
    rd_data          = (MemRead && hit_stat_c) ? status_c : '0;
  end

  // Serializer next state; tx is precomputed from the state being entered
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_pop_c = 1'b0;
    baud_end_c = (baud_q == BAUD_LAST);

    if (state_q != IDLE) begin
      baud_d = baud_end_c ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          shift_d    = fifo_dout;
          state_d    = START;
        end
      end
      START: begin
        if (baud_end_c) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (baud_end_c) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_end_c) begin
          if (!fifo_empty) begin
            fifo_pop_c = 1'b1;
            shift_d    = fifo_dout;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Sticky overflow: a dropped push sets it, a status write with bit 3 clears it, set wins
  always_comb begin
    overflow_d = overflow_q;
    if (wr_stat_c && write_data[OVF]) begin
      overflow_d = 1'b0;
    end
    if (wr_data_c && fifo_full && !fifo_pop_c) begin
      overflow_d = 1'b1;
    end
  end

  // State registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the RV32I core's data bus, alongside the instruction/data memory. It replaces the simulation-only character console at address 0x0080_0000. The core writes a byte to the data register; the byte is queued in a small FIFO and serialized as 8N1 on `tx`. A status register lets firmware poll for space or completion.

## Interface
- `BASE_ADDR`, 32'h0080_0000, byte address of the data register; the status register is at `BASE_ADDR+4`.
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; must be ≥2.
- `FIFO_DEPTH`, 8, number of queued bytes; must be a power of two, ≥2.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `address` in 32: core byte address, unshifted.
- `write_data` in 32: core store data.
- `MemWrite` in 1: store strobe, one cycle per store.
- `MemRead` in 1: load strobe.
- `rd_hit` out 1: `address` decodes to `BASE_ADDR` or `BASE_ADDR+4` while `MemRead`=1; the SoC read mux uses it to select `rd_data`.
- `rd_data` out 32: read data.
- `tx` out 1: serial output, idle high.

## Operation
- Address decode is an exact 32-bit compare against the two register addresses; all other addresses are ignored.
- Write to DATA: push `write_data[7:0]`; bits [31:8] are ignored.
  - FIFO full with no pop in the same cycle: the byte is dropped and sticky `overflow` is set.
  - FIFO full with a pop in the same cycle: the push is accepted.
- Write to STATUS: if `write_data[3]`=1, clear `overflow`; all other bits are ignored.
- Read DATA returns 0.
- Read STATUS returns {28'b0, overflow, fifo_empty, fifo_full, tx_busy} (bit3..bit0).
- `rd_data` is combinational and is 0 whenever `rd_hit`=0.
- `tx_busy` = (state != IDLE).
- Serializer FSM, with a baud counter counting 0..CLKS_PER_BIT-1:
  - IDLE: `tx`=1. If the FIFO is not empty, pop into an 8-bit shift register, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first. After each CLKS_PER_BIT cycles, shift right and increment the index. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full = MSBs differ and low bits are equal.
  - empty = pointers are equal.

## Timing
- Reset values: `tx`=1, state IDLE, baud counter 0, FIFO empty, `overflow`=0, `rd_hit`=0, `rd_data`=0. No frame is in progress.
- Reset asserted mid-frame aborts the frame. `tx` returns to 1 on the next edge and queued bytes are discarded.
- `tx` is driven from a register; it must have no combinational path from the bus.
- Write latency: a store accepted at edge E0 makes the FIFO non-empty after E0. At E1 the FSM pops and `tx` goes low. Start bit occupies E1..E1+CLKS_PER_BIT.
- One frame is exactly 10×CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- STATUS reflects register state before the current edge; a read and a write to the same register in one cycle cannot occur.
- `overflow` set and clear in the same cycle (impossible on one bus; defined anyway): set wins.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP).
  - Register offsets: DATA_OFS=0, STATUS_OFS=4.
  - Status bit positions: BUSY=0, FULL=1, EMPTY=2, OVF=3.
- Sub-module `sync_fifo`: parameterized width/depth; push/pop/full/empty/dout; first-word-fall-through. It holds the byte queue.
- Top contains decode, status register, and serializer FSM.
- SoC integration drives `address` unshifted (not `>>2`), and ORs `rd_data` into the read path under `rd_hit`.

## Test plan
- Reset, then idle 50 cycles: `tx`=1 throughout; STATUS read = 0x4.
- Single write 0x41 to 0x0080_0000 with CLKS_PER_BIT=16 → `tx` low from the next edge for 16 cycles. Then bits 1,0,0,0,0,0,1,0 at 16 cycles each, then stop high. `tx_busy` is 1 for 160 cycles.
- Burst write "Hi\n" (0x48, 0x69, 0x0A) on consecutive cycles → three contiguous frames totalling 480 cycles. The bench UART monitor decodes the same three bytes.
- Write 10 bytes 0x00..0x09 back-to-back with FIFO_DEPTH=8:
  - 0x00 pops on the following edge, so the next 8 fill the FIFO and 0x09 is dropped.
  - STATUS bit3=1.
  - 9 bytes 0x00..0x08 are transmitted.
  - A write of 0x8 to STATUS clears bit3.
- Assert `rst` at the midpoint of bit 3 of a frame → `tx`=1 on the next edge, STATUS=0x4, and no further frames are sent.
- Read 0x0080_0008 and write 0x0080_000C → `rd_hit`=0, `rd_data`=0, and no FIFO change.
